// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
//   Request/response bundle between the ALU front end (master) and the
//   bit-serial add/subtract controller (slave).
//
//   start    : request a new operation (master -> slave)
//   sub      : 0 = src1+src2, 1 = src1-src2 (master -> slave)
//   src1     : operand 1, WIDTH bits (master -> slave)
//   src2     : operand 2, WIDTH bits (master -> slave)
//   busy     : operation in progress (slave -> master)
//   done     : one-cycle result-valid pulse (slave -> master)
//   result   : sum/difference, WIDTH bits (slave -> master)
//   cout     : carry out of the MSB (slave -> master)
//   overflow : signed overflow (slave -> master)
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, src1, src2,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, sub, src1, src2,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial add/subtract controller. Latches two WIDTH-bit operands on an
//   accepted start and drives a single shared full_adder LSB-first, one bit
//   per clock, keeping the carry in a flop between cycles. A one-cycle done
//   pulse follows the last bit; result/cout/overflow are held until the next
//   accepted start begins overwriting them.
//
//   Parameters : WIDTH (2..64) operand/result width
//   Ports      : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - serial_add_ctrl_if.slave (start/sub/src1/src2 in,
//                       busy/done/result/cout/overflow out)
//   Option     : define SERIAL_ADD_OVF_EN to capture the MSB carry-in and
//                produce signed overflow; otherwise overflow is tied to 0.
//
//   Also contains full_adder, the 1-bit adder cell being time-shared.
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic sum_o,
  output logic co_o
);
  assign sum_o = a_i ^ b_i ^ ci_i;
  assign co_o  = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_add_ctrl_if.slave     bus
);
  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sub_q, sub_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic fa_sum, fa_co;

  // Subtraction is a + ~b + 1: b is inverted bit by bit and the +1 enters as
  // the initial carry loaded at start.
  full_adder u_fa (
    .a_i   (a_q[cnt_q]),
    .b_i   (b_q[cnt_q] ^ sub_q),
    .ci_i  (carry_q),
    .sum_o (fa_sum),
    .co_o  (fa_co)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.src1;
          b_d     = bus.src2;
          sub_d   = bus.sub;
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Result is rewritten in place; upper bits keep the previous result
        // until their turn comes.
        result_d[cnt_q] = fa_sum;
        carry_d         = fa_co;
        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB during this cycle.
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value, independent of statement order.
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // All outputs come straight from flops (state decode is of the state flop).
  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract controller that time-shares a single `full_adder` cell across all bits of a WIDTH-bit operation. It latches two operands on a start request and steps the 1-bit adder LSB-first, one bit per clock, holding the carry in a flop between cycles. It raises a one-cycle done pulse with the result, carry-out and (optionally) signed overflow. It sits between the lab ALU front end and the shared 1-bit adder datapath, trading latency for area.

## Interface
- `WIDTH`, default 32: operand/result width in bits; legal range 2..64.

- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: request a new operation; sampled only when idle or done.
- `sub` input 1: 0 computes src1+src2; 1 computes src1-src2 (two's complement).
- `src1` input WIDTH: operand 1; latched on accepted start.
- `src2` input WIDTH: operand 2; latched on accepted start.
- `busy` output 1: high while the operation is in progress (RUN state).
- `done` output 1: one-cycle pulse when the result is valid.
- `result` output WIDTH: sum/difference; held stable from done until the next accepted start.
- `cout` output 1: carry out of the MSB; held with `result`.
- `overflow` output 1: signed overflow; held with `result`.

## Operation
- Internally instantiates one `full_adder`. Its inputs are bit `k` of the latched src1, bit `k` of the latched src2 XOR `sub_q`, and the carry flop.
- States:
  - IDLE: `busy`=0, `done`=0. An accepted start latches src1, src2 and sub, clears the bit counter, and loads the carry flop with `sub`. The next state is RUN.
  - RUN: each cycle, the adder `sum` is written to `result[k]`, the adder `cout` is written to the carry flop, and k increments. After bit WIDTH-1, the next state is DONE.
  - DONE: `done`=1 for this cycle only.
    - If `start`=1, accept it exactly as in IDLE and go to RUN; `result` is not cleared until overwritten bit by bit.
    - Otherwise go to IDLE.
- `start` while in RUN is ignored; no queuing, and the latched operands are unaffected.
- Result register bits are updated in place. Bits >= k still hold the previous result during RUN, so downstream logic must qualify `result` with `done`/`!busy`.
- `cout` is the final carry flop value. For subtraction, `cout`=1 means no borrow (src1 >= src2 unsigned).
- `overflow` is the carry into the MSB XOR the carry out of the MSB. It is captured during the bit WIDTH-1 cycle.
- The bit counter width is clog2(WIDTH); the counter never wraps past WIDTH-1.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, `cout`=0, `overflow`=0, carry flop=0, counter=0.
- `rst` has priority over everything, including `start` in the same cycle. Reset mid-RUN abandons the operation with no done pulse.
- Start accepted at edge T0. `busy`=1 during cycles T0+1 .. T0+WIDTH. `done`=1 during cycle T0+WIDTH+1.
- Latency from start to done is WIDTH+1 cycles.
- Back-to-back throughput is one operation per WIDTH+1 cycles, achieved when start is held or re-asserted during DONE.
- `busy` and `done` are never high in the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SERIAL_ADD_OVF_EN`:
  - Defined: the MSB carry-in is captured and `overflow` is computed as above.
  - Undefined: `overflow` is tied to 0 and the capture flop is removed. All other behaviour and timing are identical.

## Test plan
All scenarios use WIDTH=8; T0 is the start cycle.
- Add: 0x7F + 0x01, sub=0 -> done at T0+9, result=0x80, cout=0, overflow=1 (0 if `SERIAL_ADD_OVF_EN` is undefined).
- Subtract: 0x05 - 0x07, sub=1 -> result=0xFE, cout=0, overflow=0. Then 0x80 - 0x01 -> result=0x7F, cout=1, overflow=1.
- Carry wrap: 0xFF + 0x01 -> result=0x00, cout=1, overflow=0.
- Ignored start: pulse start with new operands at T0+3 while busy -> first result is unchanged, exactly one done pulse, and the state returns to IDLE.
- Reset mid-op: assert rst at T0+4 -> next cycle busy=0, result=0, no done. A new start after reset completes normally (0x10+0x20 -> 0x30).
- Back-to-back: hold start through DONE with 0x01+0x02 then 0x03+0x04 -> done pulses at T0+9 and T0+18 with results 0x03 and 0x07. Busy goes high again at T0+10.
